// File: rtl/prng_pkg.sv
// Constants and FSM state type shared by the Park-Miller forward and inverse generators.
package prng_pkg;

    localparam int unsigned OPW = 31;

    localparam logic [OPW-1:0] PRNG_M     = 31'h7FFF_FFFF;
    localparam logic [OPW-1:0] PRNG_A     = 31'd16807;
    localparam logic [OPW-1:0] PRNG_A_INV = 31'd1407677000;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

endpackage

// File: rtl/prng_rev_if.sv
// Four-phase start/done request bus of the PRNG blocks.
interface prng_rev_if;

    logic [31:0] i_seed;
    logic        i_start;
    logic        i_cont;
    logic        o_done;
    logic [31:0] o_rand;

    modport master (
        output i_seed,
        output i_start,
        output i_cont,
        input  o_done,
        input  o_rand
    );

    modport slave (
        input  i_seed,
        input  i_start,
        input  i_cont,
        output o_done,
        output o_rand
    );

endinterface

// File: rtl/mod_m_add.sv
// Combinational add modulo a Mersenne modulus via end-around carry.
module mod_m_add
    import prng_pkg::*;
#(
    parameter logic [OPW-1:0] M = PRNG_M
) (
    input  logic [OPW-1:0] i_a,
    input  logic [OPW-1:0] i_b,
    output logic [OPW-1:0] o_r
);

    logic [OPW:0]   w_sum;
    logic [OPW-1:0] w_fold;

    // With both operands at most M the folded sum cannot carry out again.
    always_comb begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b};
        w_fold = w_sum[OPW-1:0] + {{(OPW-1){1'b0}}, w_sum[OPW]};
        o_r    = (w_fold == M) ? '0 : w_fold;
    end

endmodule

// File: rtl/prng_rev.sv
// Inverse Park-Miller step: rand = x * A_INV mod M by a bit-serial shift/add Horner loop.
module prng_rev
    import prng_pkg::*;
#(
    parameter logic [OPW-1:0] M     = PRNG_M,
    parameter logic [OPW-1:0] A_INV = PRNG_A_INV
) (
    input  logic         clk,
    input  logic         rst,
    prng_rev_if.slave    bus
);

    state_t         r_state;
    logic [OPW-1:0] r_x;
    logic [OPW-1:0] r_acc;
    logic [4:0]     r_cnt;
    logic           r_done;
    logic [31:0]    r_rand;

    logic [31:0]    w_opnd;
    logic [OPW-1:0] w_x_red;
    logic [OPW-1:0] w_rot;
    logic [OPW-1:0] w_addend;
    logic [OPW-1:0] w_step;

    assign w_opnd   = bus.i_cont ? r_rand : bus.i_seed;
    // Rotating a reduced value left doubles it modulo 2^31-1.
    assign w_rot    = {r_acc[OPW-2:0], r_acc[OPW-1]};
    assign w_addend = A_INV[r_cnt] ? r_x : '0;

    mod_m_add #(
        .M (M)
    ) u_reduce (
        .i_a (w_opnd[OPW-1:0]),
        .i_b ({{(OPW-1){1'b0}}, w_opnd[31]}),
        .o_r (w_x_red)
    );

    mod_m_add #(
        .M (M)
    ) u_step (
        .i_a (w_rot),
        .i_b (w_addend),
        .o_r (w_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_rand  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_start) begin
                        r_x     <= w_x_red;
                        r_acc   <= '0;
                        r_cnt   <= 5'd30;
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    r_acc <= w_step;
                    if (r_cnt == 5'd0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes; afterwards wait for start to drop.
                    if (!r_done) begin
                        r_rand <= {1'b0, r_acc};
                        r_done <= 1'b1;
                    end else if (!bus.i_start) begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_done = r_done;
    assign bus.o_rand = r_rand;

endmodule

// File: tb/tb_prng_rev.sv
// Scoreboard bench for prng_rev: directed vectors, handshake corner cases and a model sweep.
module tb_prng_rev;

    localparam longint unsigned MM   = 64'd2147483647;
    localparam longint unsigned AINV = 64'd1407677000;
    localparam longint unsigned AFWD = 64'd16807;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [30:0] exp_q[$];
    string       name_q[$];

    prng_rev_if bus ();

    prng_rev u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [30:0] red(input logic [31:0] v);
        longint unsigned t;
        t = 64'(v);
        return 31'(t % MM);
    endfunction

    function automatic logic [30:0] mulmod(input logic [30:0] a, input longint unsigned b);
        longint unsigned p;
        p = 64'(a) * b;
        return 31'(p % MM);
    endfunction

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Full four-phase request; the result itself is checked by the monitor.
    task automatic req(input logic [31:0] seed, input logic cont, input logic [30:0] expv,
                       input string name);
        int lat;
        @(negedge clk);
        bus.i_seed  = seed;
        bus.i_cont  = cont;
        bus.i_start = 1'b1;
        exp_q.push_back(expv);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        bus.i_seed = ~seed;
        bus.i_cont = ~cont;
        lat = 0;
        while (!bus.o_done && lat < 64) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check({name, "_latency"}, 64'(lat), 64'd32);
        @(negedge clk);
        bus.i_start = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_done_fall"}, 64'(bus.o_done), 64'd0);
    endtask

    initial begin : monitor
        logic        prev;
        logic [30:0] e;
        string       nm;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_done && !prev) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_done: got rand %0d, required no result",
                             bus.o_rand);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (bus.o_rand !== {1'b0, e}) begin
                        n_errors++;
                        $display("FAIL %s: got rand %0d, required %0d", nm, bus.o_rand, e);
                    end
                end
            end
            prev = bus.o_done;
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [30:0] x;
        int          lat;
        int          rises;
        logic        prevd;
        logic [31:0] s;
        logic [31:0] rt_seeds[5];

        bus.i_seed  = '0;
        bus.i_cont  = 1'b0;
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_done", 64'(bus.o_done), 64'd0);
        check("reset_rand", 64'(bus.o_rand), 64'd0);
        rst = 1'b0;

        // Operand after reset with cont=1 is rand=0.
        req(32'd5, 1'b1, 31'd0, "cont_after_reset");
        req(32'd16807, 1'b0, 31'd1, "inv_16807");
        req(32'd1, 1'b0, 31'd1407677000, "inv_1");
        req(32'd282475249, 1'b0, 31'd16807, "inv_282475249");
        req(32'd999, 1'b1, 31'd1, "chain_cont");
        req(32'd1622650073, 1'b0, 31'd282475249, "inv_seq3");
        req(32'd2007237709, 1'b0, 31'd1458777923, "inv_seq10");
        req(32'd101027544, 1'b0, 31'd470211272, "inv_seq7");
        req(32'd0, 1'b0, 31'd0, "zero");
        req(32'd2147483647, 1'b0, 31'd0, "modulus");
        req(32'hFFFF_FFFF, 1'b0, 31'd1407677000, "all_ones");
        req(32'h8000_0000, 1'b0, 31'd1407677000, "bit31_only");

        rt_seeds[0] = 32'd1749629467;
        rt_seeds[1] = 32'h7B81_8935;
        rt_seeds[2] = 32'h142E_4ECE;
        rt_seeds[3] = 32'h6849_3A1B;
        rt_seeds[4] = 32'h73F1_2C81;
        foreach (rt_seeds[i]) begin
            req({1'b0, mulmod(rt_seeds[i][30:0], AFWD)}, 1'b0, rt_seeds[i][30:0], "round_trip");
        end

        // start released during MUL: exactly one cycle of done.
        @(negedge clk);
        bus.i_seed  = 32'd282475249;
        bus.i_cont  = 1'b0;
        bus.i_start = 1'b1;
        exp_q.push_back(31'd16807);
        name_q.push_back("drop_in_mul");
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        lat = 5;
        while (!bus.o_done && lat < 64) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("drop_latency", 64'(lat), 64'd32);
        @(posedge clk);
        #1;
        check("drop_done_width", 64'(bus.o_done), 64'd0);
        repeat (40) @(negedge clk);

        // start held high: a single result, done held, no restart.
        @(negedge clk);
        bus.i_seed  = 32'd1;
        bus.i_start = 1'b1;
        exp_q.push_back(31'd1407677000);
        name_q.push_back("held_start");
        rises = 0;
        prevd = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_done && !prevd) rises++;
            prevd = bus.o_done;
        end
        check("held_rises", 64'(rises), 64'd1);
        check("held_done_high", 64'(bus.o_done), 64'd1);
        @(negedge clk);
        bus.i_start = 1'b0;
        @(posedge clk);
        #1;
        check("held_done_fall", 64'(bus.o_done), 64'd0);

        // Reset at MUL cycle 10 abandons the request.
        @(negedge clk);
        bus.i_seed  = 32'd1;
        bus.i_start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        bus.i_start = 1'b0;
        #1;
        check("abort_rand_async", 64'(bus.o_rand), 64'd0);
        check("abort_done_async", 64'(bus.o_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_done_quiet", 64'(bus.o_done), 64'd0);
        check("abort_rand_quiet", 64'(bus.o_rand), 64'd0);
        req(32'd16807, 1'b0, 31'd1, "post_abort");

        for (int i = 0; i < 1000; i++) begin
            s = $urandom;
            req(s, 1'b0, mulmod(red(s), AINV), "rand_model");
        end
        for (int i = 0; i < 200; i++) begin
            x = 31'($urandom_range(32'h7FFF_FFFE, 0));
            req({1'b0, mulmod(x, AFWD)}, 1'b0, x, "rand_inverse");
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prng_rev.md
PRNG_REV -- requirements
Module: prng_rev

Purpose: inverse step of the Park-Miller minimal-standard generator. Output = x * 16807^-1 mod (2^31-1), so prng_rev(prng(x)) = x. Uses the same four-phase start/done handshake as prng.

Interface
REQ-001 Parameter M, default 2147483647, modulus (2^31-1; Mersenne form required).
REQ-002 Parameter A_INV, default 1407677000, modular inverse of 16807 mod M.
REQ-003 clk  in  1  single clock; all state is rising-edge triggered.
REQ-004 rst  in  1  reset; asynchronous assert, active-high.
REQ-005 seed  in  32  operand for a fresh request.
REQ-006 start  in  1  request; level, four-phase handshake.
REQ-007 cont  in  1  when high at request, the operand is the current rand instead of seed.
REQ-008 done  out  1  result valid; held until start is low.
REQ-009 rand  out  32  result; bit 31 always 0; holds its value between requests.

Function
REQ-010 FSM states SHALL be IDLE, MUL and DONE.
REQ-011 IDLE with start=1 at an edge SHALL:
- latch operand x = (cont ? rand : seed) mod M, fully reduced, so 32'hFFFFFFFF -> 1 and M -> 0;
- clear acc to 0;
- set bit counter to 30;
- go to MUL.
REQ-012 MUL SHALL perform one Horner step per cycle, MSB first: acc = (2*acc mod M) + (A_INV[cnt] ? x : 0) mod M; decrement cnt.
REQ-013 2*acc mod M SHALL be a 31-bit rotate-left of acc.
REQ-014 Modular add SHALL compute s = a + b (32 bits), then r = s[30:0] + s[31]; a result equal to M SHALL map to 0.
REQ-015 After the cnt=0 step, FSM SHALL enter DONE.
REQ-016 In DONE, rand SHALL be set to {1'b0, acc} and done SHALL be 1.
REQ-017 done SHALL rise exactly 32 rising edges after the edge that sampled start=1 in IDLE.
REQ-018 DONE SHALL hold while start=1. When start=0 at an edge, FSM SHALL go to IDLE and done SHALL fall at that edge.
REQ-019 start falling during MUL SHALL NOT abort the computation. done is then high for exactly one cycle.
REQ-020 start held high continuously SHALL produce exactly one result. A new request requires start low for at least one edge.
REQ-021 Changes to seed or cont during MUL/DONE SHALL have no effect.
REQ-022 Operand 0 SHALL yield 0; this is the fixed point and needs no special case.

Reset
REQ-023 rst=1 SHALL immediately force: state IDLE, done 0, rand 0, acc 0, x 0, cnt 0.
REQ-024 Reset during MUL or DONE SHALL abandon the request; no done pulse SHALL follow.
REQ-025 After reset deassert, the first request with cont=1 SHALL use operand 0 and yield 0.

Structure
REQ-026 Package prng_pkg SHALL hold:
- PRNG_M, PRNG_A (16807), PRNG_A_INV;
- the FSM state enum;
- operand width 31.
The forward prng imports the same constants.
REQ-027 The modular add (REQ-014) SHALL be sub-module mod_m_add. It is combinational, 31-bit in / 31-bit out, and is used both for operand reduction and for the Horner step.
REQ-028 No multiplier primitives SHALL be used; the datapath is shift/add only.

Verification
REQ-029 seed=16807, cont=0, four-phase handshake -> rand=1; done exactly 32 edges after start sampled.
REQ-030 seed=1 -> rand=1407677000. Then seed=282475249 -> rand=16807. Then cont=1 -> rand=1 (chained from 16807).
REQ-031 seed=0 -> 0; seed=2147483647 -> 0; seed=32'hFFFFFFFF -> 1407677000.
REQ-032 Round trip: seed 1749629467 through prng, its rand fed to prng_rev -> 1749629467. Repeat for 32'h7B818935, 32'h142E4ECE, 32'h68493A1B, 32'h73F12C81.
REQ-033 Checks:
- rst pulsed at cycle 10 of MUL -> done stays 0; rand=0; next request is correct.
- start dropped at cycle 5 of MUL -> single-cycle done with correct rand.
- start held high for 100 cycles -> one result, no restart.
REQ-034 Random: 1000 seeds checked against a model x*A_INV mod M; inverse property checked against a forward model.
